// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared types and segment codes for seven-segment display blocks
package seg_pkg;

  localparam int T1MS = 100000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GAP  = 2'd1,
    S_SHOW = 2'd2
  } state_e;

  // Segment order a..g, active-low
  localparam logic [6:0] SEG_0   = 7'b0000001;
  localparam logic [6:0] SEG_1   = 7'b1001111;
  localparam logic [6:0] SEG_2   = 7'b0010010;
  localparam logic [6:0] SEG_3   = 7'b0000110;
  localparam logic [6:0] SEG_4   = 7'b1001100;
  localparam logic [6:0] SEG_5   = 7'b0100100;
  localparam logic [6:0] SEG_6   = 7'b0100000;
  localparam logic [6:0] SEG_7   = 7'b0001111;
  localparam logic [6:0] SEG_8   = 7'b0000000;
  localparam logic [6:0] SEG_9   = 7'b0000100;
  localparam logic [6:0] SEG_OFF = 7'b1111111;

  typedef struct packed {
    logic [15:0] digits;
    logic [3:0]  dp_mask;
    logic [3:0]  blank_mask;
  } frame_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// rtl/seg_scan_ctrl_if.sv - frame load and display bus for the segment scanner
interface seg_scan_ctrl_if;
  logic        ENABLE;
  logic        LOAD;
  logic [15:0] DIGITS;
  logic [3:0]  DP_MASK;
  logic [3:0]  BLANK_MASK;
  logic        READY;
  logic [11:0] DISP;

  modport master (
    output ENABLE, LOAD, DIGITS, DP_MASK, BLANK_MASK,
    input  READY, DISP
  );

  modport slave (
    input  ENABLE, LOAD, DIGITS, DP_MASK, BLANK_MASK,
    output READY, DISP
  );
endinterface

// File: rtl/seg7_encode.sv
// rtl/seg7_encode.sv - BCD to active-low seven-segment decoder, non-decimal codes dark
module seg7_encode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// rtl/seg_scan_ctrl.sv - four-digit multiplexed display scanner with frame-aligned updates
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int DWELL = T1MS,
  parameter int GAP   = 1000
) (
  input  logic            CLK,
  input  logic            RST,
  seg_scan_ctrl_if.slave  bus
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] GAP_END   = CW'(GAP - 1);
  localparam logic [CW-1:0] DWELL_END = CW'(DWELL - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  frame_t        pend_q, pend_d;
  frame_t        shown_q, shown_d;
  logic          pv_q, pv_d;
  logic [11:0]   disp_q, disp_d;

  logic [3:0]    digit;
  logic [6:0]    seg;

  assign digit = shown_q.digits[{idx_q, 2'b00} +: 4];

  seg7_encode u_enc (
    .bcd (digit),
    .seg (seg)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    shown_d = shown_q;
    pv_d    = pv_q;

    if (bus.ENABLE) begin
      case (state_q)
        S_IDLE: begin
          state_d = S_GAP;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
        S_GAP: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == GAP_END) state_d = S_SHOW;
        end
        S_SHOW: begin
          if (cnt_q == DWELL_END) begin
            state_d = S_GAP;
            cnt_d   = '0;
            idx_d   = idx_q + 2'd1;
            // Content only swaps between frames so a frame is never torn
            if (idx_q == 2'd3 && pv_q) begin
              shown_d = pend_q;
              pv_d    = 1'b0;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = 2'd0;
        end
      endcase
    end else begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = 2'd0;
    end

    if (state_q == S_IDLE && pv_q) begin
      shown_d = pend_q;
      pv_d    = 1'b0;
    end

    // Acceptance uses the pre-edge PV, so a load on the boundary waits a frame
    if (bus.LOAD && !pv_q) begin
      pend_d = '{digits: bus.DIGITS, dp_mask: bus.DP_MASK, blank_mask: bus.BLANK_MASK};
      pv_d   = 1'b1;
    end
  end

  always_comb begin
    disp_d = 12'hFFF;
    if (bus.ENABLE && state_q == S_SHOW) begin
      disp_d[11:8] = shown_q.blank_mask[idx_q] ? 4'hF : ~(4'b0001 << idx_q);
      disp_d[7:1]  = seg;
      disp_d[0]    = ~shown_q.dp_mask[idx_q];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      pend_q  <= '0;
      shown_q <= '0;
      pv_q    <= 1'b0;
      disp_q  <= 12'hFFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      shown_q <= shown_d;
      pv_q    <= pv_d;
      disp_q  <= disp_d;
    end
  end

  assign bus.READY = !pv_q;
  assign bus.DISP  = disp_q;

endmodule
